// File: rtl/graph_mem_pkg.sv
// Shared types and constants for the graph distance memory.
package graph_mem_pkg;

  // Controller modes: INIT sweeps the RAM with INIT_VALUE, RUN serves requests.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } graph_mem_state_e;

  // Width of the saturating collision counter.
  localparam int COLL_CNT_W = 16;

  // "Infinite distance" fill word. It is truncated to DATA_WIDTH at the top
  // level, so it stays all-ones for any DATA_WIDTH up to 64.
  localparam logic [63:0] DEFAULT_INIT_VALUE = '1;

endpackage

// File: rtl/graph_mem_core.sv
// Raw dual-port storage: two independent write ports and two registered
// read ports. Reads return the contents from before this cycle's writes.
// There is no reset; the controller overwrites every word after reset.
module graph_mem_core #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [WORD_W-1:0] wdata_a,
  output logic [WORD_W-1:0] rdata_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WORD_W-1:0] wdata_b,
  output logic [WORD_W-1:0] rdata_b
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rdata_a_q;
  logic [WORD_W-1:0] rdata_b_q;

  // Writes and read-first registered reads; the upper level never lets both
  // ports write the same address in one cycle.
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wdata_a;
    if (we_b) mem[addr_b] <= wdata_b;
    rdata_a_q <= mem[addr_a];
    rdata_b_q <= mem[addr_b];
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;

endmodule

// File: rtl/graph_memory_pipe.sv
// Dual-port graph distance memory with an init sweep, a 1- or 2-cycle read
// pipeline, same-address write collision handling and optional parity.
// Optional feature: define GRAPH_MEM_PARITY_EN to store one even-parity bit
// per word and flag perr_x on reads that fail the check.
// Handshake: a request is accepted in any cycle with req_x=1 while in RUN;
// there is no backpressure, and every accepted request yields exactly one
// qv_x pulse READ_LATENCY cycles later. Requests during INIT are dropped.
module graph_memory_pipe
  import graph_mem_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    ADDR_WIDTH   = 5,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = DATA_WIDTH'(DEFAULT_INIT_VALUE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic                  qv_a,
  output logic                  perr_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic                  qv_b,
  output logic                  perr_b,
  input  logic                  init_start,
  output logic                  busy,
  output logic                  collision,
  output logic [COLL_CNT_W-1:0] collision_cnt,
  output graph_mem_state_e      dbg_state
);

`ifdef GRAPH_MEM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int WORD_W = DATA_WIDTH + PAR_W;

  // Stored word: parity bit (when enabled) above the data.
  function automatic logic [WORD_W-1:0] encode(input logic [DATA_WIDTH-1:0] d);
`ifdef GRAPH_MEM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  graph_mem_state_e        state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_addr_q, init_addr_d;
  logic                    collision_q, collision_d;
  logic [COLL_CNT_W-1:0]   coll_cnt_q, coll_cnt_d;

  // Per-port pipeline, index 0 = port A, 1 = port B.
  logic [1:0]                  v1_q, v1_d, wt1_q, wt1_d;
  logic [1:0][DATA_WIDTH-1:0]  wd1_q, wd1_d;
  logic [1:0]                  v2_q, v2_d, perr2_q, perr2_d;
  logic [1:0][DATA_WIDTH-1:0]  res2_q, res2_d, hold_q, hold_d;
  logic [1:0][DATA_WIDTH-1:0]  res1, q_out;
  logic [1:0]                  perr1, qv_out, perr_out;
  logic [1:0][WORD_W-1:0]      rdata;

  logic                  run, acc_a, acc_b, wr_a, wr_b, coll;
  logic                  core_we_a, core_we_b;
  logic [ADDR_WIDTH-1:0] core_addr_a;
  logic [WORD_W-1:0]     core_wdata_a, core_wdata_b;

  // Request qualification and core port steering (port A carries the sweep).
  always_comb begin
    run          = (state_q == RUN);
    acc_a        = run & req_a;
    acc_b        = run & req_b;
    wr_a         = acc_a & we_a;
    wr_b         = acc_b & we_b;
    coll         = wr_a & wr_b & (addr_a == addr_b);
    core_we_a    = run ? wr_a : 1'b1;
    core_addr_a  = run ? addr_a : init_addr_q;
    core_wdata_a = run ? encode(data_a) : encode(INIT_VALUE);
    core_we_b    = wr_b & ~coll;
    core_wdata_b = encode(data_b);
  end

  graph_mem_core #(
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_WIDTH)
  ) u_core (
    .clk     (clk),
    .we_a    (core_we_a),
    .addr_a  (core_addr_a),
    .wdata_a (core_wdata_a),
    .rdata_a (rdata[0]),
    .we_b    (core_we_b),
    .addr_b  (addr_b),
    .wdata_b (core_wdata_b),
    .rdata_b (rdata[1])
  );

  // INIT/RUN controller: sweep one address per cycle, restart on init_start.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    case (state_q)
      INIT: begin
        if (init_start) begin
          init_addr_d = '0;
        end else if (&init_addr_q) begin
          state_d     = RUN;
          init_addr_d = '0;
        end else begin
          init_addr_d = init_addr_q + ADDR_WIDTH'(1);
        end
      end
      RUN: begin
        if (init_start) begin
          state_d     = INIT;
          init_addr_d = '0;
        end
      end
      default: begin
        state_d     = INIT;
        init_addr_d = '0;
      end
    endcase
  end

  // Collision pulse and saturating counter, both visible one cycle after the
  // colliding writes (aligned with qv at READ_LATENCY=1).
  always_comb begin
    collision_d = coll;
    coll_cnt_d  = coll_cnt_q;
    if (coll && (coll_cnt_q != '1)) coll_cnt_d = coll_cnt_q + COLL_CNT_W'(1);
  end

  // Read pipeline: stage 1 merges write-through data with the RAM read,
  // stage 2 adds a cycle when READ_LATENCY=2, and a hold register keeps q_x.
  always_comb begin
    v1_d     = {acc_b, acc_a};
    wt1_d    = {wr_b, wr_a};
    wd1_d[0] = data_a;
    wd1_d[1] = coll ? data_a : data_b;
    for (int p = 0; p < 2; p++) begin
      res1[p] = wt1_q[p] ? wd1_q[p] : rdata[p][DATA_WIDTH-1:0];
`ifdef GRAPH_MEM_PARITY_EN
      perr1[p] = v1_q[p] & ~wt1_q[p] & (^rdata[p]);
`else
      perr1[p] = 1'b0;
`endif
      v2_d[p]     = v1_q[p];
      res2_d[p]   = res1[p];
      perr2_d[p]  = perr1[p];
      qv_out[p]   = (READ_LATENCY == 2) ? v2_q[p] : v1_q[p];
      q_out[p]    = qv_out[p] ? ((READ_LATENCY == 2) ? res2_q[p] : res1[p]) : hold_q[p];
      perr_out[p] = qv_out[p] & ((READ_LATENCY == 2) ? perr2_q[p] : perr1[p]);
      hold_d[p]   = q_out[p];
    end
  end

  // State and pipeline registers; reset flushes everything but the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_addr_q <= '0;
      collision_q <= 1'b0;
      coll_cnt_q  <= '0;
      v1_q        <= '0;
      wt1_q       <= '0;
      wd1_q       <= '0;
      v2_q        <= '0;
      perr2_q     <= '0;
      res2_q      <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      collision_q <= collision_d;
      coll_cnt_q  <= coll_cnt_d;
      v1_q        <= v1_d;
      wt1_q       <= wt1_d;
      wd1_q       <= wd1_d;
      v2_q        <= v2_d;
      perr2_q     <= perr2_d;
      res2_q      <= res2_d;
      hold_q      <= hold_d;
    end
  end

  assign q_a           = q_out[0];
  assign qv_a          = qv_out[0];
  assign perr_a        = perr_out[0];
  assign q_b           = q_out[1];
  assign qv_b          = qv_out[1];
  assign perr_b        = perr_out[1];
  assign busy          = (state_q == INIT);
  assign collision     = collision_q;
  assign collision_cnt = coll_cnt_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_graph_memory_pipe.sv
// Bench for graph_memory_pipe: two instances (READ_LATENCY 1 and 2) share the
// same stimulus and are compared against a transaction-level memory model.
module tb_graph_memory_pipe;
  import graph_mem_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          req_a, we_a, req_b, we_b, init_start;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] data_a, data_b;

  logic [1:0]        qv_a, qv_b, perr_a, perr_b, busy, collision;
  logic [DW-1:0]     q_a [2];
  logic [DW-1:0]     q_b [2];
  logic [15:0]       cnt [2];
  graph_mem_state_e  st  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    graph_memory_pipe #(
      .DATA_WIDTH   (DW),
      .ADDR_WIDTH   (AW),
      .READ_LATENCY (g + 1)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_a         (req_a),
      .we_a          (we_a),
      .addr_a        (addr_a),
      .data_a        (data_a),
      .q_a           (q_a[g]),
      .qv_a          (qv_a[g]),
      .perr_a        (perr_a[g]),
      .req_b         (req_b),
      .we_b          (we_b),
      .addr_b        (addr_b),
      .data_b        (data_b),
      .q_b           (q_b[g]),
      .qv_b          (qv_b[g]),
      .perr_b        (perr_b[g]),
      .init_start    (init_start),
      .busy          (busy[g]),
      .collision     (collision[g]),
      .collision_cnt (cnt[g]),
      .dbg_state     (st[g])
    );
  end

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          va;
    logic [DW-1:0] da;
    logic          vb;
    logic [DW-1:0] db;
  } res_t;

  logic [DW-1:0] mdl_mem [DEPTH];
  bit            mdl_busy;
  int            mdl_idx;
  int unsigned   mdl_cnt;
  bit            mdl_coll;
  res_t          dly_q [$];           // one-cycle delay line for the latency-2 instance
  logic [1:0]    e_qv_a, e_qv_b;
  logic [DW-1:0] e_q_a [2];
  logic [DW-1:0] e_q_b [2];

  task automatic model_reset();
    mdl_busy = 1; mdl_idx = 0; mdl_cnt = 0; mdl_coll = 0;
    e_qv_a = '0; e_qv_b = '0;
    for (int d = 0; d < 2; d++) begin e_q_a[d] = '0; e_q_b[d] = '0; end
    dly_q.delete();
    dly_q.push_back('0);
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs, clock it, then advance the model so that
  // e_* hold what each instance should show just after this edge.
  task automatic step(input bit ra, input bit wa, input int aa, input logic [DW-1:0] da,
                      input bit rb, input bit wb, input int ab, input logic [DW-1:0] db,
                      input bit ist);
    res_t now, old;
    bit   coll;
    req_a = ra; we_a = wa; addr_a = aa[AW-1:0]; data_a = da;
    req_b = rb; we_b = wb; addr_b = ab[AW-1:0]; data_b = db;
    init_start = ist;
    @(posedge clk); #1;
    now = '0; coll = 0;
    if (mdl_busy) begin
      mdl_mem[mdl_idx] = 16'hFFFF;
      if (ist) mdl_idx = 0;
      else if (mdl_idx == DEPTH - 1) begin mdl_busy = 0; mdl_idx = 0; end
      else mdl_idx++;
    end else begin
      coll = ra && wa && rb && wb && (aa == ab);
      if (ra) begin now.va = 1; now.da = wa ? da : mdl_mem[aa]; end
      if (rb) begin now.vb = 1; now.db = coll ? da : (wb ? db : mdl_mem[ab]); end
      if (ra && wa) mdl_mem[aa] = da;
      if (rb && wb && !coll) mdl_mem[ab] = db;
      if (ist) begin mdl_busy = 1; mdl_idx = 0; end
    end
    mdl_coll = coll;
    if (coll && mdl_cnt < 65535) mdl_cnt++;
    e_qv_a[0] = now.va; if (now.va) e_q_a[0] = now.da;
    e_qv_b[0] = now.vb; if (now.vb) e_q_b[0] = now.db;
    dly_q.push_back(now);
    old = dly_q.pop_front();
    e_qv_a[1] = old.va; if (old.va) e_q_a[1] = old.da;
    e_qv_b[1] = old.vb; if (old.vb) e_q_b[1] = old.db;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0, 0, '0, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    req_a = 0; we_a = 0; addr_a = '0; data_a = '0;
    req_b = 0; we_b = 0; addr_b = '0; data_b = '0; init_start = 0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      checks++; if (busy[d] !== 1'b1) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 1", d, busy[d]); end
      checks++; if ({qv_a[d], qv_b[d], perr_a[d], perr_b[d], collision[d]} !== 5'b0) begin errors++; $display("FAIL reset_flags[%0d]: got %b expected 00000", d, {qv_a[d], qv_b[d], perr_a[d], perr_b[d], collision[d]}); end
      checks++; if (q_a[d] !== '0 || q_b[d] !== '0) begin errors++; $display("FAIL reset_q[%0d]: got %h/%h expected 0000/0000", d, q_a[d], q_b[d]); end
      checks++; if (cnt[d] !== 16'd0) begin errors++; $display("FAIL reset_cnt[%0d]: got %0d expected 0", d, cnt[d]); end
      checks++; if (st[d] !== INIT) begin errors++; $display("FAIL reset_state[%0d]: got %0d expected INIT", d, st[d]); end
    end
    rst_n = 1'b1;
    n = 0;
    while (busy[0] === 1'b1 && n < 100) begin n++; step(1, 0, n % DEPTH, '0, 1, 1, 3, 16'h1234, 0); end
    checks++; if (n != 32) begin errors++; $display("FAIL reset_busy_len: got %0d cycles expected 32", n); end
    for (int d = 0; d < 2; d++) begin
      checks++; if (busy[d] !== 1'b0 || st[d] !== RUN) begin errors++; $display("FAIL run_after_init[%0d]: got busy=%b state=%0d expected busy=0 RUN", d, busy[d], st[d]); end
    end
  endtask

  task automatic test_read_all();
    logic [DW-1:0] exp_q [$];
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) begin
        step(1, 0, i, '0, 1, 0, DEPTH - 1 - i, '0, 0);
        exp_q.push_back(16'hFFFF);
        checks++; if (qv_a[0] !== 1'b1 || q_a[0] !== 16'hFFFF || qv_b[0] !== 1'b1 || q_b[0] !== 16'hFFFF) begin errors++; $display("FAIL init_read_lat1 addr %0d: got qv=%b%b q=%h/%h expected 11 ffff/ffff", i, qv_a[0], qv_b[0], q_a[0], q_b[0]); end
      end else begin
        idle(1);
      end
      if (i > 0) begin
        checks++; if (qv_a[1] !== 1'b1 || q_a[1] !== exp_q[0] || q_b[1] !== exp_q[0]) begin errors++; $display("FAIL init_read_lat2 addr %0d: got qv=%b q=%h/%h expected 1 %h", i - 1, qv_a[1], q_a[1], q_b[1], exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic test_collision();
    step(1, 1, 7, 16'h1111, 1, 1, 7, 16'h2222, 0);
    checks++; if (collision[0] !== 1'b1 || cnt[0] !== 16'd1) begin errors++; $display("FAIL collision_pulse: got coll=%b cnt=%0d expected 1 1", collision[0], cnt[0]); end
    checks++; if (qv_b[0] !== 1'b1 || q_b[0] !== 16'h1111) begin errors++; $display("FAIL collision_q_b: got qv=%b q=%h expected 1 1111", qv_b[0], q_b[0]); end
    idle(1);
    checks++; if (collision[0] !== 1'b0 || cnt[1] !== 16'd1) begin errors++; $display("FAIL collision_one_cycle: got coll=%b cnt=%0d expected 0 1", collision[0], cnt[1]); end
    checks++; if (qv_b[1] !== 1'b1 || q_b[1] !== 16'h1111) begin errors++; $display("FAIL collision_q_b_lat2: got qv=%b q=%h expected 1 1111", qv_b[1], q_b[1]); end
    step(0, 0, 0, '0, 1, 0, 7, '0, 0);
    checks++; if (q_b[0] !== 16'h1111) begin errors++; $display("FAIL collision_stored: got %h expected 1111", q_b[0]); end
  endtask

  task automatic test_cross_port();
    step(1, 1, 4, 16'h0001, 0, 0, 0, '0, 0);
    step(1, 1, 4, 16'hBEEF, 1, 0, 4, '0, 0);
    checks++; if (q_b[0] !== 16'h0001 || q_a[0] !== 16'hBEEF) begin errors++; $display("FAIL read_first: got q_b=%h q_a=%h expected 0001 beef", q_b[0], q_a[0]); end
    step(0, 0, 0, '0, 1, 0, 4, '0, 0);
    checks++; if (q_b[0] !== 16'hBEEF || q_b[1] !== 16'h0001) begin errors++; $display("FAIL after_write: got %h/%h expected beef/0001", q_b[0], q_b[1]); end
  endtask

  task automatic test_latency2();
    step(1, 1, 3, 16'h00A5, 0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 1, 0, 3, '0, 0);
    checks++; if (qv_b[1] !== 1'b0 || qv_b[0] !== 1'b1 || q_b[0] !== 16'h00A5) begin errors++; $display("FAIL lat_1cyc: got qv2=%b qv1=%b q1=%h expected 0 1 00a5", qv_b[1], qv_b[0], q_b[0]); end
    idle(1);
    checks++; if (qv_b[1] !== 1'b1 || q_b[1] !== 16'h00A5) begin errors++; $display("FAIL lat_2cyc: got qv=%b q=%h expected 1 00a5", qv_b[1], q_b[1]); end
    checks++; if (qv_b[0] !== 1'b0 || q_b[0] !== 16'h00A5) begin errors++; $display("FAIL q_hold: got qv=%b q=%h expected 0 00a5", qv_b[0], q_b[0]); end
  endtask

  task automatic test_init_restart();
    int n;
    step(0, 0, 0, '0, 0, 0, 0, '0, 1);
    checks++; if (busy[0] !== 1'b1 || busy[1] !== 1'b1) begin errors++; $display("FAIL init_from_run: got busy=%b expected 11", busy); end
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 2, 16'h5555, 1, 0, 4, '0, 0);
      checks++; if (qv_a !== 2'b00 || qv_b !== 2'b00) begin errors++; $display("FAIL init_ignores_req: got qv_a=%b qv_b=%b expected 00 00", qv_a, qv_b); end
    end
    step(0, 0, 0, '0, 0, 0, 0, '0, 1);
    n = 0;
    while (busy[0] === 1'b1 && n < 100) begin n++; idle(1); end
    checks++; if (n != 32) begin errors++; $display("FAIL restart_busy_len: got %0d cycles expected 32", n); end
    step(1, 0, 4, '0, 1, 0, 2, '0, 0);
    checks++; if (q_a[0] !== 16'hFFFF || q_b[0] !== 16'hFFFF) begin errors++; $display("FAIL reinit_values: got %h/%h expected ffff/ffff", q_a[0], q_b[0]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3), DW'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3), DW'($urandom), 0);
      for (int d = 0; d < 2; d++) begin
        checks++; if (qv_a[d] !== e_qv_a[d] || q_a[d] !== e_q_a[d]) begin errors++; $display("FAIL rand_a[%0d] cyc %0d: got qv=%b q=%h expected %b %h", d, i, qv_a[d], q_a[d], e_qv_a[d], e_q_a[d]); end
        checks++; if (qv_b[d] !== e_qv_b[d] || q_b[d] !== e_q_b[d]) begin errors++; $display("FAIL rand_b[%0d] cyc %0d: got qv=%b q=%h expected %b %h", d, i, qv_b[d], q_b[d], e_qv_b[d], e_q_b[d]); end
        checks++; if (collision[d] !== mdl_coll || cnt[d] !== mdl_cnt[15:0]) begin errors++; $display("FAIL rand_coll[%0d] cyc %0d: got %b %0d expected %b %0d", d, i, collision[d], cnt[d], mdl_coll, mdl_cnt); end
        checks++; if (perr_a[d] !== 1'b0 || perr_b[d] !== 1'b0 || busy[d] !== mdl_busy) begin errors++; $display("FAIL rand_status[%0d] cyc %0d: got perr=%b%b busy=%b expected 00 %b", d, i, perr_a[d], perr_b[d], busy[d], mdl_busy); end
      end
    end
  endtask

`ifdef GRAPH_MEM_PARITY_EN
  task automatic test_parity();
    g_dut[0].u_dut.u_core.mem[9][0] = ~g_dut[0].u_dut.u_core.mem[9][0];
    g_dut[1].u_dut.u_core.mem[9][0] = ~g_dut[1].u_dut.u_core.mem[9][0];
    step(1, 0, 9, '0, 1, 0, 10, '0, 0);
    checks++; if (perr_a[0] !== 1'b1 || perr_b[0] !== 1'b0) begin errors++; $display("FAIL parity_lat1: got %b%b expected 10", perr_a[0], perr_b[0]); end
    idle(1);
    checks++; if (perr_a[1] !== 1'b1 || perr_a[0] !== 1'b0) begin errors++; $display("FAIL parity_lat2: got %b/%b expected 1/0", perr_a[1], perr_a[0]); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_read_all();
    test_collision();
    test_cross_port();
    test_latency2();
    test_init_restart();
    test_random();
`ifdef GRAPH_MEM_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
